// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
//   Measures period and high time of up to CapWidth incoming PWM signals and
//   presents the results on the device bus as a read-only responder.
//
//   Each channel runs: 2-flop synchronizer -> (optional glitch filter) ->
//   edge detect -> IDLE/HIGH/LOW FSM with a saturating cycle counter ->
//   capture registers (period_q, high_q) plus sticky valid/ovf flags.
//
// Parameters
//   CapWidth    number of capture channels (1..16)
//   CapCtrSize  counter/result width in clk_i cycles (2..16)
//
// Configuration macro
//   PWM_CAPTURE_FILTER_EN  when defined, a per-channel glitch filter sits after
//                          the synchronizer: the filtered level follows the
//                          synchronized level only after they have differed for
//                          3 consecutive cycles. Pin-to-capture latency grows
//                          from 3 to 6 cycles; pulses under 3 cycles vanish.
//
// Ports
//   clk_i            clock
//   rst_ni           asynchronous active-low reset
//   device_req_i     bus request (one response per request)
//   device_addr_i    byte address, only [9:0] decoded
//   device_we_i      write enable; writes are accepted and ignored (read 0)
//   device_be_i      byte enables, ignored
//   device_wdata_i   write data, ignored
//   device_rvalid_o  response valid, one cycle after each request
//   device_rdata_o   registered read data, holds when there is no request
//   pwm_i            asynchronous PWM inputs
//
// Handshake
//   There is no back-pressure: a request sampled on a clk_i edge always
//   produces device_rvalid_o=1 with device_rdata_o valid for the following
//   cycle, so back-to-back requests each get their own response.
//
// Register map (addr[9:0])
//   0x000 + 4*i  CH_i    [31:16] period_q, [15:0] high_q (zero-extended)
//                        reading clears valid[i] and ovf[i]
//   0x100        STATUS  [CapWidth-1:0] valid, [16+CapWidth-1:16] ovf
//   other               read as 0
// -----------------------------------------------------------------------------
module pwm_capture #(
   parameter int CapWidth   = 4,
   parameter int CapCtrSize = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                device_req_i,
   input  logic [31:0]         device_addr_i,
   input  logic                device_we_i,
   input  logic [3:0]          device_be_i,
   input  logic [31:0]         device_wdata_i,
   output logic                device_rvalid_o,
   output logic [31:0]         device_rdata_o,
   input  logic [CapWidth-1:0] pwm_i
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_e;

   localparam logic [CapCtrSize-1:0] CtrMax = '1;
   localparam logic [CapCtrSize-1:0] CtrOne = CapCtrSize'(1);

   // ---------------------------------------------------------------------------
   // Input synchronizer
   // ---------------------------------------------------------------------------
   logic [CapWidth-1:0] sync1_q;
   logic [CapWidth-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= '0;
         sync_q  <= '0;
      end else begin
         sync1_q <= pwm_i;
         sync_q  <= sync1_q;
      end
   end

   // Level fed to the edge detector.
   logic [CapWidth-1:0] level;

`ifdef PWM_CAPTURE_FILTER_EN
   // Glitch filter: filt_q follows sync_q only after a 3-cycle disagreement.
   // The run counter restarts whenever the two agree again, so a short pulse
   // never reaches the edge detector.
   logic [CapWidth-1:0] filt_q;
   logic [1:0]          run_q [CapWidth];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         filt_q <= '0;
         for (int i = 0; i < CapWidth; i++) begin
            run_q[i] <= 2'd0;
         end
      end else begin
         for (int i = 0; i < CapWidth; i++) begin
            if (sync_q[i] != filt_q[i]) begin
               if (run_q[i] == 2'd2) begin
                  filt_q[i] <= sync_q[i];
                  run_q[i]  <= 2'd0;
               end else begin
                  run_q[i] <= run_q[i] + 2'd1;
               end
            end else begin
               run_q[i] <= 2'd0;
            end
         end
      end
   end

   assign level = filt_q;
`else
   assign level = sync_q;
`endif

   // ---------------------------------------------------------------------------
   // Edge detect
   // ---------------------------------------------------------------------------
   logic [CapWidth-1:0] level_d_q;
   logic [CapWidth-1:0] rise;
   logic [CapWidth-1:0] fall;

   assign rise = level & ~level_d_q;
   assign fall = ~level & level_d_q;

   // ---------------------------------------------------------------------------
   // Per-channel measurement state
   // ---------------------------------------------------------------------------
   state_e                state_q  [CapWidth];
   logic [CapCtrSize-1:0] ctr_q    [CapWidth];
   logic [CapCtrSize-1:0] hi_lat_q [CapWidth];
   logic [CapCtrSize-1:0] period_q [CapWidth];
   logic [CapCtrSize-1:0] high_q   [CapWidth];
   logic [CapWidth-1:0]   valid_q;
   logic [CapWidth-1:0]   ovf_q;

   // sat: counter hit all-ones while measuring; it takes priority over edges.
   // capture: a result (normal or saturated) is written this cycle.
   logic [CapWidth-1:0] sat;
   logic [CapWidth-1:0] capture;
   logic [CapWidth-1:0] rd_clr;

   always_comb begin
      sat     = '0;
      capture = '0;
      for (int i = 0; i < CapWidth; i++) begin
         sat[i]     = ((state_q[i] == HIGH) || (state_q[i] == LOW)) &&
                      (ctr_q[i] == CtrMax);
         capture[i] = sat[i] || ((state_q[i] == LOW) && rise[i]);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         level_d_q <= '0;
         valid_q   <= '0;
         ovf_q     <= '0;
         for (int i = 0; i < CapWidth; i++) begin
            state_q[i]  <= IDLE;
            ctr_q[i]    <= '0;
            hi_lat_q[i] <= '0;
            period_q[i] <= '0;
            high_q[i]   <= '0;
         end
      end else begin
         level_d_q <= level;
         for (int i = 0; i < CapWidth; i++) begin
            case (state_q[i])
               IDLE: begin
                  if (rise[i]) begin
                     state_q[i] <= HIGH;
                     ctr_q[i]   <= CtrOne;
                  end
               end
               HIGH: begin
                  if (sat[i]) begin
                     period_q[i] <= CtrMax;
                     high_q[i]   <= CtrMax;
                     state_q[i]  <= IDLE;
                  end else if (fall[i]) begin
                     hi_lat_q[i] <= ctr_q[i];
                     ctr_q[i]    <= ctr_q[i] + CtrOne;
                     state_q[i]  <= LOW;
                  end else begin
                     ctr_q[i] <= ctr_q[i] + CtrOne;
                  end
               end
               LOW: begin
                  // A rise in the saturation cycle is deliberately dropped.
                  if (sat[i]) begin
                     period_q[i] <= CtrMax;
                     high_q[i]   <= hi_lat_q[i];
                     state_q[i]  <= IDLE;
                  end else if (rise[i]) begin
                     period_q[i] <= ctr_q[i];
                     high_q[i]   <= hi_lat_q[i];
                     ctr_q[i]    <= CtrOne;
                     state_q[i]  <= HIGH;
                  end else begin
                     ctr_q[i] <= ctr_q[i] + CtrOne;
                  end
               end
               default: begin
                  state_q[i] <= IDLE;
               end
            endcase

            // A capture in the same cycle as a CH_i read beats the clear.
            if (capture[i]) begin
               valid_q[i] <= 1'b1;
            end else if (rd_clr[i]) begin
               valid_q[i] <= 1'b0;
            end

            if (sat[i]) begin
               ovf_q[i] <= 1'b1;
            end else if (rd_clr[i] && !capture[i]) begin
               ovf_q[i] <= 1'b0;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Bus decode and read mux
   // ---------------------------------------------------------------------------
   logic [9:0]  offset;
   logic [5:0]  ch_idx;
   logic        is_ch;
   logic        is_status;
   logic [31:0] rd_word;

   assign offset    = device_addr_i[9:0];
   assign ch_idx    = offset[7:2];
   assign is_ch     = (offset[9:8] == 2'b00) && (offset[1:0] == 2'b00);
   assign is_status = (offset == 10'h100);

   always_comb begin
      rd_word = '0;
      rd_clr  = '0;
      if (is_status) begin
         rd_word[CapWidth-1:0]   = valid_q;
         rd_word[16 +: CapWidth] = ovf_q;
      end else if (is_ch) begin
         // Channel indices at or beyond CapWidth match nothing and read 0.
         for (int i = 0; i < CapWidth; i++) begin
            if (ch_idx == 6'(i)) begin
               rd_word[16 +: CapCtrSize] = period_q[i];
               rd_word[0 +: CapCtrSize]  = high_q[i];
               rd_clr[i] = device_req_i && !device_we_i;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         device_rvalid_o <= 1'b0;
         device_rdata_o  <= '0;
      end else begin
         device_rvalid_o <= device_req_i;
         if (device_req_i) begin
            device_rdata_o <= device_we_i ? 32'h0 : rd_word;
         end
      end
   end

   // Bus fields that carry no meaning for a read-only responder.
   logic unused_bus_bits;
   assign unused_bus_bits = ^{device_be_i, device_wdata_i, device_addr_i[31:10]};

endmodule
